// File: rtl/wb_slave_pkg.sv
// Shared types for the Wishbone burst slave: cycle-type and burst-type encodings,
// the slave state enum and the wrap-size helper used by the address generator.
package wb_slave_pkg;

   typedef enum logic [2:0] {
      CtiClassic = 3'b000,
      CtiIncr    = 3'b010,
      CtiEob     = 3'b111
   } cti_e;

   typedef enum logic [1:0] {
      BteLinear = 2'b00,
      BteWrap4  = 2'b01,
      BteWrap8  = 2'b10,
      BteWrap16 = 2'b11
   } bte_e;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StResp,
      StErr
   } state_e;

   // Number of low address bits that increment for a burst type; a wrap larger than
   // the address space (and linear bursts) wrap over the full width.
   function automatic int unsigned wrap_bits(input bte_e bte, input int unsigned adr_w);
      int unsigned bits;
      case (bte)
         BteWrap4:  bits = 2;
         BteWrap8:  bits = 3;
         BteWrap16: bits = 4;
         default:   bits = adr_w;
      endcase
      if (bits > adr_w) bits = adr_w;
      return bits;
   endfunction

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Combinational burst next-address generator: linear (modulo 2^ADR_W) or wrap-4/8/16,
// where only the low wrap bits increment and the upper bits are held.
module wb_burst_addr_gen
   import wb_slave_pkg::*;
#(
   parameter int unsigned ADR_W = 4
) (
   input  logic [ADR_W-1:0] adr_i,
   input  logic [1:0]       bte_i,
   output logic [ADR_W-1:0] nxt_adr_o
);

   logic [ADR_W-1:0] inc;
   logic [ADR_W-1:0] mask;
   int unsigned      bits;

   // Increment the whole address, then keep only the bits inside the wrap window.
   always_comb begin
      bits = wrap_bits(bte_e'(bte_i), ADR_W);
      inc  = adr_i + 1'b1;
      mask = '0;
      for (int unsigned i = 0; i < ADR_W; i++) begin
         mask[i] = (i < bits);
      end
      nxt_adr_o = (adr_i & ~mask) | (inc & mask);
   end

endmodule

// File: rtl/wb_burst_slave.sv
// Wishbone B3 slave endpoint with registered-feedback read-burst prefetch (CTI/BTE),
// address-range checking and a level req/ack backend port.
// Optional macro WB_SLAVE_TIMEOUT_EN: abort a backend request with ERR_O after WAIT_MAX
// cycles without be_ack_i.
module wb_burst_slave #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned GRAN      = 8,
   parameter int unsigned ADR_W     = 4,
   parameter int unsigned NUM_WORDS = 16,
   parameter int unsigned WAIT_MAX  = 15
) (
   input  logic                     CLK_I,
   input  logic                     RST_I,
   input  logic                     CYC_I,
   input  logic                     STB_I,
   input  logic                     WE_I,
   input  logic [ADR_W-1:0]         ADR_I,
   input  logic [DATA_W-1:0]        DAT_I,
   input  logic [DATA_W/GRAN-1:0]   SEL_I,
   input  logic [2:0]               CTI_I,
   input  logic [1:0]               BTE_I,
   output logic [DATA_W-1:0]        DAT_O,
   output logic                     ACK_O,
   output logic                     ERR_O,
   output logic                     be_req_o,
   output logic                     be_we_o,
   output logic [ADR_W-1:0]         be_adr_o,
   output logic [DATA_W-1:0]        be_dat_o,
   output logic [DATA_W/GRAN-1:0]   be_sel_o,
   input  logic                     be_ack_i,
   input  logic [DATA_W-1:0]        be_dat_i
);
   import wb_slave_pkg::*;

   localparam int unsigned   SEL_W     = DATA_W / GRAN;
   localparam logic [ADR_W:0] NumWordsW = (ADR_W + 1)'(NUM_WORDS);

   state_e              state_q, state_d;
   logic [ADR_W-1:0]    adr_q, adr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdat_q, wdat_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [DATA_W-1:0]   rdat_q, rdat_d;
   logic [ADR_W-1:0]    nxt_adr;
   logic                bus_stb, adr_hit, adr_oob, nxt_ok, prefetch, timeout;

   wb_burst_addr_gen #(
      .ADR_W (ADR_W)
   ) u_addr_gen (
      .adr_i     (adr_q),
      .bte_i     (BTE_I),
      .nxt_adr_o (nxt_adr)
   );

   assign bus_stb  = CYC_I & STB_I;
   assign adr_hit  = (ADR_I == adr_q);
   assign adr_oob  = ({1'b0, ADR_I} >= NumWordsW);
   assign nxt_ok   = ({1'b0, nxt_adr} < NumWordsW);
   // Only incrementing read bursts whose next beat is in range fetch ahead.
   assign prefetch = !we_q && (CTI_I == CtiIncr) && nxt_ok;

   assign DAT_O    = rdat_q;
   assign be_dat_o = wdat_q;
   assign be_sel_o = sel_q;

`ifdef WB_SLAVE_TIMEOUT_EN
   localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   logic [CntW-1:0] cnt_q, cnt_d;

   assign timeout = (state_q == StReq) && CYC_I && !be_ack_i &&
                    (cnt_q == CntW'(WAIT_MAX - 1));

   // Count unacknowledged REQ cycles; cleared whenever REQ is left or times out.
   always_comb begin
      cnt_d = '0;
      if ((state_q == StReq) && CYC_I && !be_ack_i && !timeout) cnt_d = cnt_q + 1'b1;
   end

   // Timeout counter register.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   logic unused_wait_max;
   assign unused_wait_max = (WAIT_MAX != 0);
   assign timeout         = 1'b0;
`endif

   // Next-state, latch updates and bus/backend outputs.
   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      we_d     = we_q;
      wdat_d   = wdat_q;
      sel_d    = sel_q;
      rdat_d   = rdat_q;
      ACK_O    = 1'b0;
      ERR_O    = 1'b0;
      be_req_o = 1'b0;
      be_we_o  = 1'b0;
      be_adr_o = adr_q;
      case (state_q)
         StIdle: begin
            if (bus_stb) begin
               if (adr_oob) begin
                  state_d = StErr;
               end else begin
                  adr_d   = ADR_I;
                  we_d    = WE_I;
                  wdat_d  = DAT_I;
                  sel_d   = SEL_I;
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            be_req_o = 1'b1;
            be_we_o  = we_q;
            if (be_ack_i) begin
               if (!we_q) rdat_d = be_dat_i;
               state_d = StResp;
            end else if (timeout) begin
               state_d = StErr;
            end
         end
         StResp: begin
            if (bus_stb && adr_hit) begin
               ACK_O = 1'b1;
               if (prefetch) begin
                  be_req_o = 1'b1;
                  be_adr_o = nxt_adr;
                  adr_d    = nxt_adr;
                  if (be_ack_i) rdat_d = be_dat_i;
                  else          state_d = StReq;
               end else begin
                  state_d = StIdle;
               end
            end else if (bus_stb) begin
               // Master moved to another address: drop any prefetched data.
               state_d = StIdle;
            end
         end
         StErr: begin
            ERR_O   = bus_stb;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // An abandoned bus cycle withdraws the backend request at once.
      if (!CYC_I) begin
         state_d  = StIdle;
         be_req_o = 1'b0;
      end
   end

   // State and latched transaction registers.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q <= StIdle;
         adr_q   <= '0;
         we_q    <= 1'b0;
         wdat_q  <= '0;
         sel_q   <= '0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         we_q    <= we_d;
         wdat_q  <= wdat_d;
         sel_q   <= sel_d;
         rdat_q  <= rdat_d;
      end
   end

endmodule

// File: tb/tb_wb_burst_slave.sv
// Self-checking bench for wb_burst_slave: randomized classic reads/writes and bursts
// against a backend memory model and an arithmetic burst-address reference.
module tb_wb_burst_slave;

   localparam int AW = 5;
   localparam int NW = 16;
   localparam int WM = 15;

   logic          CLK_I = 1'b0;
   logic          RST_I = 1'b0;
   logic          CYC_I, STB_I, WE_I;
   logic [AW-1:0] ADR_I;
   logic [31:0]   DAT_I;
   logic [3:0]    SEL_I;
   logic [2:0]    CTI_I;
   logic [1:0]    BTE_I;
   logic [31:0]   DAT_O;
   logic          ACK_O, ERR_O;
   logic          be_req_o, be_we_o;
   logic [AW-1:0] be_adr_o;
   logic [31:0]   be_dat_o;
   logic [3:0]    be_sel_o;
   logic          be_ack_i;
   logic [31:0]   be_dat_i;

   int checks = 0;
   int errors = 0;

   wb_burst_slave #(
      .DATA_W    (32),
      .GRAN      (8),
      .ADR_W     (AW),
      .NUM_WORDS (NW),
      .WAIT_MAX  (WM)
   ) dut (
      .CLK_I    (CLK_I),
      .RST_I    (RST_I),
      .CYC_I    (CYC_I),
      .STB_I    (STB_I),
      .WE_I     (WE_I),
      .ADR_I    (ADR_I),
      .DAT_I    (DAT_I),
      .SEL_I    (SEL_I),
      .CTI_I    (CTI_I),
      .BTE_I    (BTE_I),
      .DAT_O    (DAT_O),
      .ACK_O    (ACK_O),
      .ERR_O    (ERR_O),
      .be_req_o (be_req_o),
      .be_we_o  (be_we_o),
      .be_adr_o (be_adr_o),
      .be_dat_o (be_dat_o),
      .be_sel_o (be_sel_o),
      .be_ack_i (be_ack_i),
      .be_dat_i (be_dat_i)
   );

   always #5 CLK_I = ~CLK_I;

   // Backend model: memory, programmable wait states, optional hold-off.
   logic [31:0] mem [32];
   int          be_wait   = 0;
   bit          be_hold   = 1'b0;
   int          wait_left = 0;

   assign be_ack_i = !be_hold && (wait_left == 0);
   assign be_dat_i = mem[be_adr_o];

   always @(posedge CLK_I) begin
      if (!be_req_o || be_ack_i) wait_left <= be_wait;
      else if (wait_left > 0)    wait_left <= wait_left - 1;
   end

   // Log of completed backend transfers.
   int          log_adr [$];
   bit          log_we  [$];
   logic [31:0] log_dat [$];
   logic [3:0]  log_sel [$];

   always @(posedge CLK_I) begin
      if (be_req_o && be_ack_i) begin
         log_adr.push_back(int'(be_adr_o));
         log_we.push_back(be_we_o);
         log_dat.push_back(be_dat_o);
         log_sel.push_back(be_sel_o);
      end
   end

   // Output activity counters, sampled mid-cycle.
   int ack_total  = 0;
   int err_total  = 0;
   int req_total  = 0;
   int both_total = 0;

   always @(negedge CLK_I) begin
      if (ACK_O)           ack_total++;
      if (ERR_O)           err_total++;
      if (be_req_o)        req_total++;
      if (ACK_O && ERR_O)  both_total++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference burst-address sequence from the wrap rules.
   function automatic int ref_next(input int a, input int bte);
      int ws;
      ws = (bte == 0) ? (1 << AW) : (2 << bte);
      if (ws > (1 << AW)) ws = 1 << AW;
      return (a / ws) * ws + ((a % ws) + 1) % ws;
   endfunction

   task automatic idle_bus();
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = '0;
      DAT_I = '0;   SEL_I = '0;   CTI_I = '0;  BTE_I = '0;
   endtask

   task automatic tick();
      @(posedge CLK_I); #1;
   endtask

   // Single beat; returns the cycle offsets (from first STB cycle) of ACK and ERR.
   task automatic classic(input int adr, input bit we, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [2:0] cti,
                          output int ack_at, output int err_at, output logic [31:0] rdata);
      ack_at = -1; err_at = -1; rdata = '0;
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = AW'(adr);
      DAT_I = dat;  SEL_I = sel;  CTI_I = cti; BTE_I = 2'b00;
      for (int c = 0; c < 60; c++) begin
         @(negedge CLK_I);
         if (ACK_O && ack_at < 0) begin ack_at = c; rdata = DAT_O; end
         if (ERR_O && err_at < 0) err_at = c;
         tick();
         if (ack_at >= 0 || err_at >= 0) break;
      end
      idle_bus();
      repeat (2) tick();
   endtask

   int          b_ack_cyc [$];
   logic [31:0] b_dat     [$];

   task automatic burst_read(input int a0, input int bte, input int len);
      int adr;
      int beat;
      bit got;
      b_ack_cyc.delete(); b_dat.delete();
      adr = a0; beat = 0;
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; SEL_I = 4'hF; DAT_I = '0;
      BTE_I = 2'(bte); ADR_I = AW'(adr);
      CTI_I = (len == 1) ? 3'b111 : 3'b010;
      for (int c = 0; c < 300 && beat < len; c++) begin
         @(negedge CLK_I);
         got = ACK_O;
         if (got) begin b_ack_cyc.push_back(c); b_dat.push_back(DAT_O); beat++; end
         tick();
         if (got && beat < len) begin
            adr   = ref_next(adr, bte);
            ADR_I = AW'(adr);
            CTI_I = (beat == len - 1) ? 3'b111 : 3'b010;
         end
      end
      idle_bus();
      repeat (2) tick();
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({DAT_O, ACK_O, ERR_O, be_req_o, be_we_o, be_adr_o, be_dat_o, be_sel_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got DAT_O=%h ACK=%b ERR=%b req=%b we=%b adr=%0d, want all 0",
                  DAT_O, ACK_O, ERR_O, be_req_o, be_we_o, be_adr_o);
      end
      @(negedge CLK_I); RST_I = 1'b1;
      tick();
   endtask

   task automatic test_classic_read();
      int a0, r0, n0, ack_at, err_at, adr, k;
      logic [31:0] rd;
      be_wait = 0;
      a0 = ack_total; r0 = req_total; n0 = log_adr.size();
      classic(3, 1'b0, '0, 4'hF, 3'b000, ack_at, err_at, rd);
      checks++;
      if (ack_at != 2 || rd !== 32'hCAFE0003) begin
         errors++;
         $display("FAIL read3: ack at %0d data %h, want ack at 2 data cafe0003", ack_at, rd);
      end
      checks++;
      if (req_total - r0 != 1 || ack_total - a0 != 1) begin
         errors++;
         $display("FAIL read3_counts: req %0d ack %0d, want 1 and 1",
                  req_total - r0, ack_total - a0);
      end
      checks++;
      if (log_adr.size() != n0 + 1) begin
         errors++;
         $display("FAIL read3_log: %0d transfers, want 1", log_adr.size() - n0);
      end else if (log_adr[n0] != 3 || log_we[n0] !== 1'b0) begin
         errors++;
         $display("FAIL read3_log: adr %0d we %b, want 3 and 0", log_adr[n0], log_we[n0]);
      end
      for (int i = 0; i < 6; i++) begin
         adr = $urandom_range(0, NW - 1);
         k   = $urandom_range(0, 3);
         be_wait = k;
         r0 = req_total;
         classic(adr, 1'b0, '0, 4'hF, 3'b000, ack_at, err_at, rd);
         checks++;
         if (ack_at != 2 + k || rd !== mem[adr] || req_total - r0 != k + 1) begin
            errors++;
            $display("FAIL rand_read: adr %0d wait %0d got ack %0d data %h req %0d, want %0d %h %0d",
                     adr, k, ack_at, rd, req_total - r0, 2 + k, mem[adr], k + 1);
         end
      end
      be_wait = 0;
   endtask

   task automatic test_write();
      int a0, n0, ack_at, err_at, adr, k;
      logic [31:0] rd, d;
      logic [3:0]  s;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin adr = 5; d = 32'h12345678; s = 4'b0011; k = 0; end
         else begin
            adr = $urandom_range(0, NW - 1); d = $urandom; s = 4'($urandom); k = $urandom_range(0, 2);
         end
         be_wait = k;
         a0 = ack_total; n0 = log_adr.size();
         classic(adr, 1'b1, d, s, 3'b000, ack_at, err_at, rd);
         checks++;
         if (ack_at != 2 + k || ack_total - a0 != 1) begin
            errors++;
            $display("FAIL write_ack: adr %0d ack at %0d count %0d, want at %0d count 1",
                     adr, ack_at, ack_total - a0, 2 + k);
         end
         checks++;
         if (log_adr.size() != n0 + 1) begin
            errors++;
            $display("FAIL write_log: %0d transfers, want 1", log_adr.size() - n0);
         end else if (log_we[n0] !== 1'b1 || log_adr[n0] != adr || log_dat[n0] !== d ||
                      log_sel[n0] !== s) begin
            errors++;
            $display("FAIL write_log: we %b adr %0d dat %h sel %b, want 1 %0d %h %b",
                     log_we[n0], log_adr[n0], log_dat[n0], log_sel[n0], adr, d, s);
         end
      end
      be_wait = 0;
   endtask

   task automatic test_burst();
      int n0, a0, bte, len, ea;
      for (int t = 0; t < 7; t++) begin
         if (t == 0) begin a0 = 6; bte = 1; len = 4; be_wait = 0; end
         else begin
            bte = $urandom_range(0, 3);
            len = $urandom_range(1, 8);
            a0  = (bte == 0) ? $urandom_range(0, NW - len) : $urandom_range(0, NW - 1);
            be_wait = $urandom_range(0, 2);
         end
         n0 = log_adr.size();
         burst_read(a0, bte, len);
         checks++;
         if (b_ack_cyc.size() != len || log_adr.size() - n0 != len) begin
            errors++;
            $display("FAIL burst_len: start %0d bte %0d acks %0d transfers %0d, want %0d",
                     a0, bte, b_ack_cyc.size(), log_adr.size() - n0, len);
         end else begin
            ea = a0;
            for (int i = 0; i < len; i++) begin
               checks++;
               if (log_adr[n0 + i] != ea || b_dat[i] !== mem[ea]) begin
                  errors++;
                  $display("FAIL burst_beat: beat %0d be_adr %0d data %h, want %0d %h",
                           i, log_adr[n0 + i], b_dat[i], ea, mem[ea]);
               end
               if (t == 0) begin
                  checks++;
                  if (b_ack_cyc[i] != 2 + i) begin
                     errors++;
                     $display("FAIL burst_timing: beat %0d ack cycle %0d, want %0d",
                              i, b_ack_cyc[i], 2 + i);
                  end
               end
               ea = ref_next(ea, bte);
            end
         end
      end
      be_wait = 0;
   endtask

   task automatic test_boundary();
      int a0, e0, r0, n0, ack_at, err_at, adr;
      logic [31:0] rd;
      for (int i = 0; i < 2; i++) begin
         adr = (i == 0) ? 16 : $urandom_range(17, 31);
         a0 = ack_total; e0 = err_total; r0 = req_total; n0 = log_adr.size();
         classic(adr, 1'b0, '0, 4'hF, 3'b000, ack_at, err_at, rd);
         checks++;
         if (err_at != 1 || ack_at != -1 || err_total - e0 != 1 || ack_total - a0 != 0) begin
            errors++;
            $display("FAIL oob: adr %0d err at %0d count %0d ack %0d, want err at 1 count 1 ack 0",
                     adr, err_at, err_total - e0, ack_total - a0);
         end
         checks++;
         if (req_total - r0 != 0 || log_adr.size() != n0) begin
            errors++;
            $display("FAIL oob_req: adr %0d req cycles %0d, want 0", adr, req_total - r0);
         end
      end
      // Incrementing read on the last word must not prefetch beyond the range.
      n0 = log_adr.size();
      classic(15, 1'b0, '0, 4'hF, 3'b010, ack_at, err_at, rd);
      checks++;
      if (ack_at != 2 || rd !== mem[15] || log_adr.size() - n0 != 1) begin
         errors++;
         $display("FAIL last_word_incr: ack %0d data %h transfers %0d, want 2 %h 1",
                  ack_at, rd, log_adr.size() - n0, mem[15]);
      end
   endtask

   task automatic test_abandon();
      int a0, e0, ack_at, err_at;
      logic [31:0] rd;
      be_hold = 1'b1;
      a0 = ack_total; e0 = err_total;
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = AW'(8); SEL_I = 4'hF;
      CTI_I = 3'b010; BTE_I = 2'b00;
      @(negedge CLK_I);
      tick();
      @(negedge CLK_I);
      checks++;
      if (be_req_o !== 1'b1) begin
         errors++;
         $display("FAIL abandon_req: be_req_o %b in request cycle, want 1", be_req_o);
      end
      tick();
      idle_bus();
      @(negedge CLK_I);
      tick();
      @(negedge CLK_I);
      checks++;
      if (be_req_o !== 1'b0 || ack_total != a0 || err_total != e0) begin
         errors++;
         $display("FAIL abandon: req %b acks %0d errs %0d, want 0 0 0",
                  be_req_o, ack_total - a0, err_total - e0);
      end
      tick();
      be_hold = 1'b0;
      classic(3, 1'b0, '0, 4'hF, 3'b000, ack_at, err_at, rd);
      checks++;
      if (ack_at != 2 || rd !== mem[3]) begin
         errors++;
         $display("FAIL after_abandon: ack %0d data %h, want 2 %h", ack_at, rd, mem[3]);
      end
   endtask

   task automatic test_wait_limit();
      int r0, e0, ack_at, err_at;
      logic [31:0] rd;
      be_hold = 1'b1;
      r0 = req_total; e0 = err_total;
`ifdef WB_SLAVE_TIMEOUT_EN
      classic(1, 1'b0, '0, 4'hF, 3'b000, ack_at, err_at, rd);
      checks++;
      if (err_at != WM + 1 || ack_at != -1 || req_total - r0 != WM) begin
         errors++;
         $display("FAIL timeout: err at %0d ack %0d req cycles %0d, want %0d -1 %0d",
                  err_at, ack_at, req_total - r0, WM + 1, WM);
      end
      @(negedge CLK_I);
      checks++;
      if (be_req_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_req: be_req_o %b after timeout, want 0", be_req_o);
      end
      tick();
      be_hold = 1'b0;
`else
      ack_at = -1; rd = '0;
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = AW'(1); SEL_I = 4'hF; CTI_I = 3'b000;
      for (int c = 0; c < 25; c++) begin
         @(negedge CLK_I);
         tick();
      end
      checks++;
      if (err_total != e0 || req_total - r0 != 24) begin
         errors++;
         $display("FAIL no_timeout: errs %0d req cycles %0d, want 0 24",
                  err_total - e0, req_total - r0);
      end
      be_hold = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK_I);
         if (ACK_O) begin ack_at = c; rd = DAT_O; end
         tick();
         if (ack_at >= 0) break;
      end
      idle_bus();
      repeat (2) tick();
      checks++;
      if (ack_at != 1 || rd !== mem[1]) begin
         errors++;
         $display("FAIL no_timeout_release: ack %0d data %h, want 1 %h", ack_at, rd, mem[1]);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int ack_at, err_at;
      logic [31:0] rd;
      be_hold = 1'b1;
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = AW'(2); SEL_I = 4'hF; CTI_I = 3'b000;
      @(negedge CLK_I);
      tick();
      @(negedge CLK_I);
      tick();
      RST_I = 1'b0;
      #1;
      checks++;
      if ({be_req_o, ACK_O, ERR_O, DAT_O, be_adr_o} !== '0) begin
         errors++;
         $display("FAIL reset_mid: req %b ack %b err %b DAT_O %h adr %0d, want all 0",
                  be_req_o, ACK_O, ERR_O, DAT_O, be_adr_o);
      end
      idle_bus();
      @(negedge CLK_I); RST_I = 1'b1;
      be_hold = 1'b0;
      tick();
      classic(3, 1'b0, '0, 4'hF, 3'b000, ack_at, err_at, rd);
      checks++;
      if (ack_at != 2 || rd !== mem[3]) begin
         errors++;
         $display("FAIL after_reset: ack %0d data %h, want 2 %h", ack_at, rd, mem[3]);
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (both_total != 0) begin
         errors++;
         $display("FAIL ack_err_overlap: %0d cycles with both high, want 0", both_total);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[3] = 32'hCAFE0003;
      idle_bus();
      test_reset();
      test_classic_read();
      test_write();
      test_burst();
      test_boundary();
      test_abandon();
      test_wait_limit();
      test_reset_mid();
      test_exclusive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
